// File: rtl/brew_v1_pkg.sv
// Shared types and defaults for the DRAM bus controller: FSM state encoding,
// timing defaults and row/column split of the word address.
package brew_v1;

  localparam int unsigned DEF_REFRESH_PERIOD   = 128;
  localparam int unsigned DEF_PRECHARGE_CYCLES = 2;
  localparam int unsigned REQ_ADDR_W           = 22;
  localparam int unsigned DRAM_ADDR_W          = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROW,
    ST_CAS_A,
    ST_CAS_B,
    ST_PRECHARGE,
    ST_REF_CAS,
    ST_REF_RAS,
    ST_REF_END
  } dram_state_e;

  function automatic logic [DRAM_ADDR_W-1:0] addr_row(input logic [REQ_ADDR_W-1:0] a);
    return a[21:11];
  endfunction

  function automatic logic [DRAM_ADDR_W-1:0] addr_col(input logic [REQ_ADDR_W-1:0] a);
    return a[10:0];
  endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval counter with a sticky pending flag; a second
// expiry while pending is absorbed rather than queued.
module dram_refresh_timer
  import brew_v1::*;
#(
  parameter int unsigned PERIOD = DEF_REFRESH_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic pending_o
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q;
  logic          pending_q;
  logic          expire;

  assign expire    = (cnt_q == '0);
  assign pending_o = pending_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= RELOAD;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= expire ? RELOAD : cnt_q - CW'(1);
      pending_q <= expire | (pending_q & ~clear_i);
    end
  end

endmodule

// File: rtl/dram_bus_ctrl.sv
// Single-port DRAM bus controller: 16-bit word accesses as two 8-bit CAS beats
// on a multiplexed row/column bus, with CAS-before-RAS refresh.
module dram_bus_ctrl
  import brew_v1::*;
#(
  parameter int unsigned REFRESH_PERIOD   = DEF_REFRESH_PERIOD,
  parameter int unsigned PRECHARGE_CYCLES = DEF_PRECHARGE_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [21:0] req_addr,
  input  logic        req_we,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        dram_nRAS,
  output logic        dram_nCAS_a,
  output logic        dram_nCAS_b,
  output logic        dram_nWE,
  output logic [10:0] dram_addr,
  input  logic [7:0]  dram_data_in,
  output logic [7:0]  dram_data_out,
  output logic        dram_data_out_en,
  input  logic        dram_nWAIT,
  output logic        dram_bus_en
);

  // One down-counter serves both the precharge hold and the two REF_RAS cycles.
  localparam int unsigned CNT_MAX = (PRECHARGE_CYCLES > 2) ? PRECHARGE_CYCLES : 2;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  dram_state_e state_q;
  logic [CW-1:0] cnt_q;
  logic          nras_q, ncas_a_q, ncas_b_q, nwe_q;
  logic [10:0]   addr_q, col_q;
  logic [7:0]    dout_q, rdata_lo_q;
  logic          oen_q, bus_en_q, we_q;
  logic [15:0]   wdata_q, rsp_rdata_q;
  logic          rsp_valid_q;
  logic          refresh_pending;
  logic          refresh_clear;
  logic          accept;

  assign req_ready     = ~rst & (state_q == ST_IDLE) & ~refresh_pending;
  assign accept        = req_valid & req_ready;
  assign refresh_clear = (state_q == ST_IDLE) & refresh_pending;

  dram_refresh_timer #(
    .PERIOD(REFRESH_PERIOD)
  ) u_refresh_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (refresh_clear),
    .pending_o(refresh_pending)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      nras_q      <= 1'b1;
      ncas_a_q    <= 1'b1;
      ncas_b_q    <= 1'b1;
      nwe_q       <= 1'b1;
      addr_q      <= '0;
      col_q       <= '0;
      dout_q      <= '0;
      rdata_lo_q  <= '0;
      oen_q       <= 1'b0;
      bus_en_q    <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      bus_en_q    <= 1'b1;
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (refresh_pending) begin
            state_q  <= ST_REF_CAS;
            ncas_a_q <= 1'b0;
            ncas_b_q <= 1'b0;
          end else if (accept) begin
            state_q <= ST_ROW;
            nras_q  <= 1'b0;
            nwe_q   <= ~req_we;
            addr_q  <= addr_row(req_addr);
            col_q   <= addr_col(req_addr);
            we_q    <= req_we;
            wdata_q <= req_wdata;
          end
        end
        ST_ROW: begin
          state_q  <= ST_CAS_A;
          addr_q   <= col_q;
          ncas_a_q <= 1'b0;
          oen_q    <= we_q;
          dout_q   <= wdata_q[7:0];
        end
        // A beat holds while nWAIT is sampled low; data is taken on the edge that ends it.
        ST_CAS_A: begin
          if (dram_nWAIT) begin
            state_q    <= ST_CAS_B;
            ncas_a_q   <= 1'b1;
            ncas_b_q   <= 1'b0;
            dout_q     <= wdata_q[15:8];
            rdata_lo_q <= dram_data_in;
          end
        end
        ST_CAS_B: begin
          if (dram_nWAIT) begin
            state_q  <= ST_PRECHARGE;
            cnt_q    <= CW'(PRECHARGE_CYCLES - 1);
            nras_q   <= 1'b1;
            ncas_b_q <= 1'b1;
            nwe_q    <= 1'b1;
            oen_q    <= 1'b0;
            if (!we_q) begin
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= {dram_data_in, rdata_lo_q};
            end
          end
        end
        ST_PRECHARGE: begin
          if (cnt_q == '0) state_q <= ST_IDLE;
          else cnt_q <= cnt_q - CW'(1);
        end
        ST_REF_CAS: begin
          state_q <= ST_REF_RAS;
          nras_q  <= 1'b0;
          cnt_q   <= CW'(1);
        end
        ST_REF_RAS: begin
          if (cnt_q == '0) begin
            state_q  <= ST_REF_END;
            nras_q   <= 1'b1;
            ncas_a_q <= 1'b1;
            ncas_b_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_REF_END: begin
          state_q <= ST_PRECHARGE;
          cnt_q   <= CW'(PRECHARGE_CYCLES - 1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid        = rsp_valid_q;
  assign rsp_rdata        = rsp_rdata_q;
  assign dram_nRAS        = nras_q;
  assign dram_nCAS_a      = ncas_a_q;
  assign dram_nCAS_b      = ncas_b_q;
  assign dram_nWE         = nwe_q;
  assign dram_addr        = addr_q;
  assign dram_data_out    = dout_q;
  assign dram_data_out_en = oen_q;
  assign dram_bus_en      = bus_en_q;

endmodule
